// File: rtl/text_line_arbiter.sv
// rtl/text_line_arbiter.sv - round-robin arbiter merging byte-stream messages into one line-wrapped text output
module text_line_arbiter #(
    parameter int N_REQ           = 4,
    parameter int LINE_LENGTH_MAX = 30,
    parameter int RESUME_ON_ERROR = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [8*N_REQ-1:0]         req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       out_valid,
    output logic [7:0]                 out_data,
    input  logic                       out_ready,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic                       err_invalid_char,
    output logic [$clog2(N_REQ)-1:0]   err_src,
    output logic                       halted
);
    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(LINE_LENGTH_MAX + 1);
    localparam logic [CW-1:0] COL_MAX = CW'(LINE_LENGTH_MAX);

    typedef enum logic [1:0] {IDLE, PASS, WRAP, HALT} state_t;

    state_t          state, state_n;
    logic            ret_idle, ret_idle_n;
    logic [GW-1:0]   rr_ptr, rr_ptr_n, grant_n, err_src_n, pick_id;
    logic [CW-1:0]   col, col_n, col_upd;
    logic            out_valid_n, err_n, pick_found;
    logic [7:0]      out_data_n, cur_data;
    logic            cur_valid, cur_last, can_load, char_ok;

    assign can_load  = !out_valid || out_ready;
    assign cur_data  = req_data[{grant_id, 3'b000} +: 8];
    assign cur_valid = req_valid[grant_id];
    assign cur_last  = req_last[grant_id];
    assign char_ok   = (cur_data >= 8'h20 && cur_data <= 8'h7E) ||
                       cur_data == 8'h09 || cur_data == 8'h0A;
    assign col_upd   = (cur_data == 8'h0A) ? '0 : col + CW'(1);

    // First requester strictly after rr_ptr, wrapping modulo N_REQ
    always_comb begin
        int j;
        pick_found = 1'b0;
        pick_id    = rr_ptr;
        j          = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(rr_ptr) + k) % N_REQ;
            if (!pick_found && req_valid[j[GW-1:0]]) begin
                pick_found = 1'b1;
                pick_id    = j[GW-1:0];
            end
        end
    end

    always_comb begin
        state_n     = state;
        ret_idle_n  = ret_idle;
        grant_n     = grant_id;
        rr_ptr_n    = rr_ptr;
        col_n       = col;
        err_n       = err_invalid_char;
        err_src_n   = err_src;
        out_data_n  = out_data;
        out_valid_n = out_valid && !out_ready;
        req_ready   = '0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_n  = pick_id;
                    rr_ptr_n = pick_id;
                    state_n  = PASS;
                end
            end
            PASS: begin
                req_ready[grant_id] = can_load;
                if (cur_valid && can_load) begin
                    if (char_ok) begin
                        out_valid_n = 1'b1;
                        out_data_n  = cur_data;
                        col_n       = col_upd;
                        if (cur_last) begin
                            ret_idle_n = 1'b1;
                            state_n    = (col_upd != '0) ? WRAP : IDLE;
                        end else if (cur_data != 8'h0A && col_upd == COL_MAX) begin
                            ret_idle_n = 1'b0;
                            state_n    = WRAP;
                        end
                    end else begin
                        // Bad character is swallowed; only the first error's source is kept
                        if (!err_invalid_char) begin
                            err_n     = 1'b1;
                            err_src_n = grant_id;
                        end
                        if (RESUME_ON_ERROR == 0) begin
                            state_n = HALT;
                        end else if (cur_last) begin
                            ret_idle_n = 1'b1;
                            state_n    = (col != '0) ? WRAP : IDLE;
                        end
                    end
                end
            end
            WRAP: begin
                if (can_load) begin
                    out_valid_n = 1'b1;
                    out_data_n  = 8'h0A;
                    col_n       = '0;
                    state_n     = ret_idle ? IDLE : PASS;
                end
            end
            HALT: begin
            end
            default: state_n = IDLE;
        endcase
        if (rst) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            ret_idle         <= 1'b0;
            grant_id         <= '0;
            rr_ptr           <= GW'(N_REQ - 1);
            col              <= '0;
            out_valid        <= 1'b0;
            out_data         <= 8'h00;
            err_invalid_char <= 1'b0;
            err_src          <= '0;
        end else begin
            state            <= state_n;
            ret_idle         <= ret_idle_n;
            grant_id         <= grant_n;
            rr_ptr           <= rr_ptr_n;
            col              <= col_n;
            out_valid        <= out_valid_n;
            out_data         <= out_data_n;
            err_invalid_char <= err_n;
            err_src          <= err_src_n;
        end
    end

    assign busy   = (state != IDLE);
    assign halted = (state == HALT);
endmodule

// File: tb/tb_text_line_arbiter.sv
// tb/tb_text_line_arbiter.sv - bench for text_line_arbiter (halting and resuming variants side by side)
module tb_text_line_arbiter;
    localparam int N    = 4;
    localparam int LMAX = 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, out_ready;
    logic [N-1:0]   rv [2], rl [2], rdy [2];
    logic [8*N-1:0] rd [2];
    logic           ov [2], bsy [2], err [2], hlt [2];
    logic [7:0]     od [2];
    logic [1:0]     gid [2], esrc [2];

    text_line_arbiter #(.N_REQ(N), .LINE_LENGTH_MAX(LMAX), .RESUME_ON_ERROR(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_data(rd[0]), .req_last(rl[0]),
        .req_ready(rdy[0]), .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready),
        .grant_id(gid[0]), .busy(bsy[0]), .err_invalid_char(err[0]), .err_src(esrc[0]),
        .halted(hlt[0]));

    text_line_arbiter #(.N_REQ(N), .LINE_LENGTH_MAX(LMAX), .RESUME_ON_ERROR(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_data(rd[1]), .req_last(rl[1]),
        .req_ready(rdy[1]), .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready),
        .grant_id(gid[1]), .busy(bsy[1]), .err_invalid_char(err[1]), .err_src(esrc[1]),
        .halted(hlt[1]));

    // Reference: owner=-1 means nobody holds the grant; nl = newline owed before anything else
    int         m_owner [2], m_gid [2], m_rr [2], m_len [2], m_esrc [2];
    bit         m_halt [2], m_nl [2], m_rel [2], m_full [2], m_err [2];
    logic [7:0] m_char [2];

    logic [8:0] mq [2][N][$];
    logic [7:0] cap [2][$];
    int         gq [2][$];
    bit         pbusy [2];
    int         n_vec = 0, n_mis = 0;
    bit         directed_mode, ordy_rand;
    logic [7:0] held [2];

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s dut%0d t=%0t: actual %0h required %0h", name, d, $time, act, exp);
        end
    endtask

    task automatic m_reset(input int d);
        m_owner[d] = -1; m_gid[d] = 0; m_rr[d] = N - 1; m_len[d] = 0; m_esrc[d] = 0;
        m_halt[d] = 0; m_nl[d] = 0; m_rel[d] = 0; m_full[d] = 0; m_err[d] = 0; m_char[d] = 8'h00;
    endtask

    function automatic bit m_room(input int d);
        return !m_full[d] || out_ready;
    endfunction

    function automatic logic [N-1:0] m_ready(input int d);
        logic [N-1:0] r = '0;
        if (!rst && m_owner[d] >= 0 && !m_halt[d] && !m_nl[d] && m_room(d)) r[m_owner[d]] = 1'b1;
        return r;
    endfunction

    function automatic bit printable(input logic [7:0] c);
        return (c >= 8'h20 && c <= 8'h7E) || c == 8'h09 || c == 8'h0A;
    endfunction

    task automatic m_step(input int d);
        bit nf, room, lst, found;
        logic [7:0] c;
        int j;
        if (rst) begin
            m_reset(d);
            return;
        end
        room  = m_room(d);
        nf    = m_full[d] && !out_ready;
        found = 0;
        if (m_halt[d]) begin
        end else if (m_owner[d] < 0) begin
            for (int k = 1; k <= N; k++) begin
                j = (m_rr[d] + k) % N;
                if (!found && rv[d][j]) begin
                    found = 1; m_owner[d] = j; m_gid[d] = j; m_rr[d] = j;
                end
            end
        end else if (m_nl[d]) begin
            if (room) begin
                nf = 1; m_char[d] = 8'h0A; m_len[d] = 0; m_nl[d] = 0;
                if (m_rel[d]) m_owner[d] = -1;
            end
        end else if (rv[d][m_owner[d]] && room) begin
            c   = rd[d][8*m_owner[d] +: 8];
            lst = rl[d][m_owner[d]];
            void'(mq[d][m_owner[d]].pop_front());
            if (printable(c)) begin
                nf = 1; m_char[d] = c;
                m_len[d] = (c == 8'h0A) ? 0 : m_len[d] + 1;
                if (lst) begin
                    if (m_len[d] != 0) begin m_nl[d] = 1; m_rel[d] = 1; end
                    else m_owner[d] = -1;
                end else if (c != 8'h0A && m_len[d] == LMAX) begin
                    m_nl[d] = 1; m_rel[d] = 0;
                end
            end else begin
                if (!m_err[d]) begin m_err[d] = 1; m_esrc[d] = m_owner[d]; end
                if (d == 0) m_halt[d] = 1;
                else if (lst) begin
                    if (m_len[d] != 0) begin m_nl[d] = 1; m_rel[d] = 1; end
                    else m_owner[d] = -1;
                end
            end
        end
        m_full[d] = nf;
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk("req_ready", d, rdy[d], m_ready(d));
            chk("out_valid", d, ov[d], m_full[d]);
            if (m_full[d]) chk("out_data", d, od[d], m_char[d]);
            chk("grant_id", d, gid[d], m_gid[d]);
            chk("busy", d, bsy[d], (m_owner[d] >= 0) || m_halt[d]);
            chk("err_invalid_char", d, err[d], m_err[d]);
            chk("err_src", d, esrc[d], m_esrc[d]);
            chk("halted", d, hlt[d], m_halt[d]);
            if (!rst && ov[d] && out_ready) cap[d].push_back(od[d]);
            if (bsy[d] && !pbusy[d]) gq[d].push_back(int'(gid[d]));
            pbusy[d] = bsy[d];
            m_step(d);
        end
    end

    task automatic gen_msg(input int d, input int i);
        int len, r;
        logic [7:0] c;
        len = 1 + $urandom % 40;
        for (int k = 0; k < len; k++) begin
            r = $urandom % 128;
            if (r < 3) c = 8'h0A;
            else if (r == 3) c = 8'h09;
            else if (r == 4) begin
                case ($urandom % 4)
                    0: c = 8'h07;
                    1: c = 8'h7F;
                    2: c = 8'h80;
                    default: c = 8'hFF;
                endcase
            end else c = 8'(8'h20 + $urandom % 95);
            mq[d][i].push_back({k == len - 1, c});
        end
    endtask

    task automatic push_both(input int i, input string s);
        logic [7:0] c;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < s.len(); k++) begin
                c = s[k];
                if (c == 8'h7E) c = 8'h0A;
                else if (c == 8'h23) c = 8'h07;
                mq[d][i].push_back({k == s.len() - 1, c});
            end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (ordy_rand) out_ready = ($urandom % 4) != 0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < N; i++) begin
                if (!directed_mode && mq[d][i].size() == 0 && $urandom % 16 == 0) gen_msg(d, i);
                if (mq[d][i].size() > 0 && (directed_mode || $urandom % 4 != 0)) begin
                    rv[d][i] = 1'b1;
                    rd[d][8*i +: 8] = mq[d][i][0][7:0];
                    rl[d][i] = mq[d][i][0][8];
                end else begin
                    rv[d][i] = 1'b0;
                    rd[d][8*i +: 8] = 8'($urandom);
                    rl[d][i] = 1'($urandom);
                end
            end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic clear_logs();
        for (int d = 0; d < 2; d++) begin
            cap[d].delete();
            gq[d].delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < N; i++) mq[d][i].delete();
        run(2);
        rst = 1'b0;
    endtask

    task automatic chk_reset_state();
        for (int d = 0; d < 2; d++) begin
            chk("rst_out_valid", d, ov[d], 0);
            chk("rst_out_data", d, od[d], 8'h00);
            chk("rst_grant_id", d, gid[d], 0);
            chk("rst_busy", d, bsy[d], 0);
            chk("rst_err", d, err[d], 0);
            chk("rst_err_src", d, esrc[d], 0);
            chk("rst_halted", d, hlt[d], 0);
            chk("rst_req_ready", d, rdy[d], 0);
        end
    endtask

    task automatic chk_cap(input string name, input int d, input string exp);
        string act = "";
        foreach (cap[d][k]) act = $sformatf("%s%c", act, (cap[d][k] == 8'h0A) ? 8'h7E : cap[d][k]);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s dut%0d: actual \"%s\" required \"%s\"", name, d, act, exp);
        end
    endtask

    task automatic chk_gnt(input string name, input int d, input string exp);
        string act = "";
        foreach (gq[d][k]) act = $sformatf("%s%0d", act, gq[d][k]);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s dut%0d: actual \"%s\" required \"%s\"", name, d, act, exp);
        end
    endtask

    initial begin
        string s;
        rst = 1'b1; out_ready = 1'b1; ordy_rand = 0; directed_mode = 1;
        for (int d = 0; d < 2; d++) begin
            rv[d] = '0; rl[d] = '0; rd[d] = '0; pbusy[d] = 0;
            m_reset(d);
        end
        do_reset();
        chk_reset_state();

        clear_logs();
        push_both(0, "AB"); push_both(2, "AB");
        run(40);
        for (int d = 0; d < 2; d++) begin
            chk_cap("two_msgs_out", d, "AB~AB~");
            chk_gnt("two_msgs_grants", d, "02");
        end

        clear_logs();
        s = "";
        for (int k = 0; k < 31; k++) s = {s, "x"};
        push_both(1, s);
        run(80);
        s = "";
        for (int k = 0; k < 30; k++) s = {s, "x"};
        s = {s, "~x~"};
        for (int d = 0; d < 2; d++) begin
            chk_cap("line_wrap_out", d, s);
            chk_gnt("line_wrap_grants", d, "1");
        end

        clear_logs();
        push_both(3, "Q~"); push_both(0, "Z");
        run(40);
        for (int d = 0; d < 2; d++) begin
            chk_cap("nl_end_out", d, "Q~Z~");
            chk_gnt("nl_end_grants", d, "30");
        end

        clear_logs();
        push_both(1, "A#B");
        run(40);
        chk_cap("halt_out", 0, "A");
        chk("halt_err", 0, err[0], 1);
        chk("halt_err_src", 0, esrc[0], 1);
        chk("halt_halted", 0, hlt[0], 1);
        chk("halt_busy", 0, bsy[0], 1);
        chk_cap("resume_out", 1, "AB~");
        chk("resume_err", 1, err[1], 1);
        chk("resume_err_src", 1, esrc[1], 1);
        chk("resume_halted", 1, hlt[1], 0);
        chk("resume_busy", 1, bsy[1], 0);
        do_reset();
        chk_reset_state();

        clear_logs();
        push_both(2, "HELLO");
        run(4);
        out_ready = 1'b0;
        for (int d = 0; d < 2; d++) held[d] = od[d];
        repeat (5) begin
            run(1);
            for (int d = 0; d < 2; d++) begin
                chk("stall_valid", d, ov[d], 1);
                chk("stall_data", d, od[d], held[d]);
                chk("stall_ready", d, rdy[d], 0);
            end
        end
        out_ready = 1'b1;
        run(40);
        for (int d = 0; d < 2; d++) chk_cap("stall_out", d, "HELLO~");

        directed_mode = 0;
        ordy_rand = 1;
        for (int blk = 0; blk < 10; blk++) begin
            do_reset();
            run(350);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
